// File: rtl/demux_chan_sequencer.sv
// Round-robin channel sequencer that drives the {chan, act} code of a 1-to-8 output demux.
// Optional break-before-make dead time between grants is enabled by defining SEQ_DEADTIME_EN.
module demux_chan_sequencer #(
   parameter int unsigned DWELL = 4,
   parameter int unsigned CNT_W = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en_i,
   input  logic [7:0] req_i,
   output logic [3:0] code_o,
   output logic       busy_o,
   output logic       grant_done_o
);

   localparam logic [CNT_W-1:0] DwellLast = CNT_W'(DWELL - 1);

   typedef enum logic [1:0] {StIdle, StGrant, StGap} state_e;

   state_e             state_q, state_d;
   logic [2:0]         chan_q, chan_d;
   logic               act_q, act_d;
   logic [2:0]         rr_ptr_q, rr_ptr_d;
   logic [CNT_W-1:0]   dwell_q, dwell_d;

   logic [2:0]         base;
   logic [2:0]         idx;
   logic [2:0]         win;
   logic               found;
   logic               start;
   logic               last;

   // At the end of a grant the pointer is still stale, so search from chan+1 directly.
   always_comb begin
      base  = (state_q == StGrant) ? chan_q + 3'd1 : rr_ptr_q;
      win   = base;
      idx   = '0;
      found = 1'b0;
      for (int i = 0; i < 8; i++) begin
         idx = base + 3'(i);
         if (!found && req_i[idx]) begin
            win   = idx;
            found = 1'b1;
         end
      end
   end

   assign start = en_i && (|req_i);
   assign last  = (dwell_q == DwellLast);

   always_comb begin
      state_d  = state_q;
      chan_d   = chan_q;
      act_d    = act_q;
      rr_ptr_d = rr_ptr_q;
      dwell_d  = dwell_q;
      case (state_q)
         StIdle: begin
            if (start) begin
               state_d = StGrant;
               chan_d  = win;
               act_d   = 1'b1;
               dwell_d = '0;
            end
         end
         StGrant: begin
            if (!last) begin
               dwell_d = dwell_q + CNT_W'(1);
            end else begin
               rr_ptr_d = chan_q + 3'd1;
`ifdef SEQ_DEADTIME_EN
               state_d = StGap;
               act_d   = 1'b0;
`else
               if (start) begin
                  chan_d  = win;
                  act_d   = 1'b1;
                  dwell_d = '0;
               end else begin
                  state_d = StIdle;
                  act_d   = 1'b0;
               end
`endif
            end
         end
`ifdef SEQ_DEADTIME_EN
         StGap: begin
            if (start) begin
               state_d = StGrant;
               chan_d  = win;
               act_d   = 1'b1;
               dwell_d = '0;
            end else begin
               state_d = StIdle;
            end
         end
`endif
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         chan_q   <= '0;
         act_q    <= 1'b0;
         rr_ptr_q <= '0;
         dwell_q  <= '0;
      end else begin
         state_q  <= state_d;
         chan_q   <= chan_d;
         act_q    <= act_d;
         rr_ptr_q <= rr_ptr_d;
         dwell_q  <= dwell_d;
      end
   end

   // chan is held while act is low so the demux select never glitches.
   assign code_o       = {chan_q, act_q};
   assign busy_o       = (state_q != StIdle);
   assign grant_done_o = (state_q == StGrant) && last;

endmodule

// File: tb/tb_demux_chan_sequencer.sv
// Self-checking bench: DWELL=4 and DWELL=1 instances share stimulus and are compared every
// cycle against a grant-countdown model; directed sequences pin the model with literal values.
module tb_demux_chan_sequencer;

`ifdef SEQ_DEADTIME_EN
   localparam bit GapEn = 1'b1;
`else
   localparam bit GapEn = 1'b0;
`endif
   localparam int G = GapEn ? 1 : 0;

   logic       clk;
   logic       rst_n;
   logic       en;
   logic [7:0] req;
   logic [3:0] code4, code1;
   logic       busy4, busy1, done4, done1;

   int n_checks = 0;
   int n_fail   = 0;

   demux_chan_sequencer #(.DWELL(4), .CNT_W(8)) u_d4 (
      .clk          (clk),
      .rst_n        (rst_n),
      .en_i         (en),
      .req_i        (req),
      .code_o       (code4),
      .busy_o       (busy4),
      .grant_done_o (done4)
   );

   demux_chan_sequencer #(.DWELL(1), .CNT_W(8)) u_d1 (
      .clk          (clk),
      .rst_n        (rst_n),
      .en_i         (en),
      .req_i        (req),
      .code_o       (code1),
      .busy_o       (busy1),
      .grant_done_o (done1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   // Model: each instance is a countdown of remaining grant cycles plus a pointer.
   int unsigned dw[2] = '{4, 1};
   int          left[2];
   bit          gap_m[2];
   logic [2:0]  mchan[2];
   logic [2:0]  mptr[2];

   function automatic logic [2:0] pick(input logic [2:0] p, input logic [7:0] r);
      for (int i = 0; i < 8; i++) begin
         logic [2:0] c;
         c = p + 3'(i);
         if (r[c]) return c;
      end
      return p;
   endfunction

   task automatic try_start(input int k);
      if (en && (|req)) begin
         mchan[k] = pick(mptr[k], req);
         left[k]  = int'(dw[k]);
      end
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < 2; k++) begin
            left[k] = 0; gap_m[k] = 1'b0; mchan[k] = '0; mptr[k] = '0;
         end
      end else begin
         for (int k = 0; k < 2; k++) begin
            if (left[k] > 0) begin
               left[k]--;
               if (left[k] == 0) begin
                  mptr[k] = mchan[k] + 3'd1;
                  if (GapEn) gap_m[k] = 1'b1;
                  else try_start(k);
               end
            end else begin
               gap_m[k] = 1'b0;
               try_start(k);
            end
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         check("code_d4", code4, {mchan[0], left[0] > 0});
         check("busy_d4", busy4, (left[0] > 0) || gap_m[0]);
         check("done_d4", done4, left[0] == 1);
         check("code_d1", code1, {mchan[1], left[1] > 0});
         check("busy_d1", busy1, (left[1] > 0) || gap_m[1]);
         check("done_d1", done1, left[1] == 1);
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((busy4 || busy1) && n < 20) begin
         cyc(1);
         n++;
      end
      check("idle_timeout", busy4 | busy1, 0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [2:0] prev;
      logic [3:0] prev1;
      bit         have_prev;
      int         ndone;
      int         n;

      rst_n = 1'b0; en = 1'b0; req = 8'h00;
      #12;
      check("rst_code", code4, 4'h0);
      check("rst_busy", busy4, 0);
      check("rst_done", done4, 0);
      check("rst_code1", code1, 4'h0);

      // Single request on channel 3.
      @(negedge clk);
      rst_n = 1'b1; en = 1'b1; req = 8'h08;
      cyc(1);
      check("t2_first", code4, 4'h7);
      check("t2_nodone", done4, 0);
      cyc(2);
      check("t2_hold", code4, 4'h7);
      cyc(1);
      check("t2_done", done4, 1);
      check("t2_last", code4, 4'h7);
      cyc(1);
      check("t2_regrant", code4, GapEn ? 4'h6 : 4'h7);
      check("t2_busy", busy4, 1);
      en = 1'b0; req = 8'h00;
      wait_idle();

      // Mid-grant drop of requests and enable on channel 2.
      en = 1'b1; req = 8'h04;
      cyc(1);
      check("t5_grant", code4, 4'h5);
      cyc(1);
      en = 1'b0; req = 8'h00;
      cyc(2);
      check("t5_full", code4, 4'h5);
      check("t5_done", done4, 1);
      cyc(1);
      check("t5_hold", code4, 4'h4);
      cyc(1);
      check("t5_code", code4, 4'h4);
      check("t5_idle", busy4, 0);

      // All requests: ascending channel order.
      en = 1'b1; req = 8'hFF;
      ndone = 0; have_prev = 1'b0; prev = '0;
      for (int i = 0; i < 32; i++) begin
         cyc(1);
         if (done4) begin
            ndone++;
            if (have_prev) check("t3_order", code4[3:1], 3'(prev + 3'd1));
            prev = code4[3:1];
            have_prev = 1'b1;
         end
      end
`ifndef SEQ_DEADTIME_EN
      check("t3_ndone", ndone, 8);
`endif

      // Asynchronous reset while channel 5 is active.
      n = 0;
      while (code4 != 4'hB && n < 40) begin
         cyc(1);
         n++;
      end
      check("t1_find5", code4, 4'hB);
      #2 rst_n = 1'b0;
      #1;
      check("t1_code", code4, 4'h0);
      check("t1_busy", busy4, 0);
      check("t1_done", done4, 0);
      @(negedge clk);
      rst_n = 1'b1; en = 1'b1; req = 8'h40;

      // Wrap and fairness around channel 6.
      cyc(1);
      check("t4_ch6", code4, 4'hD);
      req = 8'h41;
      cyc(4 + G);
      check("t4_wrap", code4, 4'h1);
      cyc(4 + G);
      check("t4_fair", code4, 4'hD);

      // DWELL=1 alternation.
      req = 8'h05;
      cyc(3);
`ifndef SEQ_DEADTIME_EN
      prev1 = code1;
      check("t6_code", (code1 == 4'h1) || (code1 == 4'h5), 1);
      for (int i = 0; i < 6; i++) begin
         cyc(1);
         check("t6_alt", code1, (prev1 == 4'h1) ? 4'h5 : 4'h1);
         check("t6_done", done1, 1);
         prev1 = code1;
      end
`endif

      // Randomized traffic with occasional asynchronous resets.
      for (int i = 0; i < 3000; i++) begin
         cyc(1);
         en = ($urandom_range(0, 3) != 0);
         case ($urandom_range(0, 3))
            0: req = 8'h00;
            1: req = 8'(1 << $urandom_range(0, 7));
            default: req = 8'($urandom);
         endcase
         if ($urandom_range(0, 299) == 0) begin
            #2 rst_n = 1'b0;
            #1;
            check("rnd_rst_code", code4, 4'h0);
            check("rnd_rst_busy", busy1, 0);
            #1 rst_n = 1'b1;
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
